// File: rtl/i2s_sample_port.sv
// I2S slave port between the codec and the sequential DSP engine.
// Received left-channel samples go to the engine with a one-cycle strobe.
// The engine's latest output sample goes back out on both slots as mono.
module i2s_sample_port #(
  parameter int data_width  = 16,
  parameter int slot_width  = 32,
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  sdin,
  output logic                  sdout,
  output logic [data_width-1:0] in_sample,
  output logic                  sample_ready,
  input  logic [data_width-1:0] out_sample,
  input  logic                  engine_ready,
  output logic                  overrun
);

  localparam int idx_w = $clog2(slot_width + 1);
  localparam logic [idx_w-1:0] idx_first = idx_w'(1);
  localparam logic [idx_w-1:0] idx_last  = idx_w'(data_width);
  localparam logic [idx_w-1:0] idx_sat   = idx_w'(slot_width);

  logic [sync_stages-1:0] bclk_sync, lrclk_sync, sdin_sync;
  logic                   bclk_s, lrclk_s, sdin_s;
  logic                   bclk_prev, lr_prev, eng_prev, armed;
  logic [idx_w-1:0]       bit_idx, idx_next;
  logic [data_width-2:0]  rx_shift;
  logic [data_width-1:0]  tx_hold;
  logic [slot_width-1:0]  tx_shift;
  logic                   rise, fall, lr_change, arm_now, capture, last_bit, eng_rise;

  assign bclk_s  = bclk_sync[sync_stages-1];
  assign lrclk_s = lrclk_sync[sync_stages-1];
  assign sdin_s  = sdin_sync[sync_stages-1];

  // Bring the codec's pins into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdin_sync  <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[sync_stages-2:0], bclk};
      lrclk_sync <= {lrclk_sync[sync_stages-2:0], lrclk};
      sdin_sync  <= {sdin_sync[sync_stages-2:0], sdin};
    end
  end

  // Edge detects and the bit index the current rise will produce.
  always_comb begin
    rise      = bclk_s & ~bclk_prev;
    fall      = ~bclk_s & bclk_prev;
    lr_change = lrclk_s != lr_prev;
    arm_now   = rise & lr_prev & ~lrclk_s;
    eng_rise  = engine_ready & ~eng_prev;
    idx_next  = bit_idx;
    if (lr_change)
      idx_next = '0;
    else if (bit_idx != idx_sat)
      idx_next = bit_idx + idx_first;
    // Index 1 is the MSB: I2S delays data by one bit after the lrclk change.
    capture  = rise & armed & ~lrclk_s & (idx_next >= idx_first) & (idx_next <= idx_last);
    last_bit = capture & (idx_next == idx_last);
  end

  // Slot tracking; arming waits for a left-slot start so no partial frame leaks out.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_prev <= 1'b0;
      lr_prev   <= 1'b0;
      eng_prev  <= 1'b0;
      bit_idx   <= '0;
      armed     <= 1'b0;
    end else begin
      bclk_prev <= bclk_s;
      eng_prev  <= engine_ready;
      if (rise) begin
        lr_prev <= lrclk_s;
        bit_idx <= idx_next;
        if (arm_now)
          armed <= 1'b1;
      end
    end
  end

  // Receive the left channel and hand each completed word to the engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift     <= '0;
      in_sample    <= '0;
      sample_ready <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_ready <= 1'b0;
      if (capture)
        rx_shift <= {rx_shift[data_width-3:0], sdin_s};
      if (last_bit) begin
        in_sample    <= {rx_shift, sdin_s};
        sample_ready <= 1'b1;
        if (!engine_ready)
          overrun <= 1'b1;
      end
    end
  end

  // Transmit; a slot always sends the tx_hold value latched at its start.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_hold  <= '0;
      tx_shift <= '0;
      sdout    <= 1'b0;
    end else begin
      if (eng_rise)
        tx_hold <= out_sample;
      if (rise && lr_change)
        tx_shift <= {tx_hold, {(slot_width - data_width){1'b0}}};
      else if (fall && armed)
        tx_shift <= {tx_shift[slot_width-2:0], 1'b0};
      if (fall)
        sdout <= armed ? tx_shift[slot_width-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_sample_port.sv
// Bench for i2s_sample_port: codec model driving bclk = clk/16, scoreboard
// for received samples, per-slot comparison of the serialised output.
module tb_i2s_sample_port;
  localparam int DW = 16;
  localparam int SW = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bclk = 1'b0;
  logic          lrclk = 1'b1;
  logic          sdin = 1'b0;
  logic          engine_ready = 1'b1;
  logic [DW-1:0] out_sample = '0;
  logic          sdout, sample_ready, overrun;
  logic [DW-1:0] in_sample;

  i2s_sample_port #(.data_width(DW), .slot_width(SW), .sync_stages(SS)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdin(sdin),
    .sdout(sdout), .in_sample(in_sample), .sample_ready(sample_ready),
    .out_sample(out_sample), .engine_ready(engine_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];

  // reference model state
  logic          m_prev_ws, m_armed, m_slot_armed, m_ovr;
  int            m_cnt;
  logic [DW-1:0] m_slot_word, m_hold;
  logic [SW-1:0] got_w, exp_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_ws    = 1'b0;
    m_armed      = 1'b0;
    m_slot_armed = 1'b0;
    m_ovr        = 1'b0;
    m_cnt        = SW;
    m_slot_word  = '0;
    // edge history is cleared, so a high engine_ready reads as a fresh edge
    m_hold       = engine_ready ? out_sample : '0;
    exp_q.delete();
  endtask

  // one bclk period: fall + 8 clk low, rise + 8 clk high
  task automatic bit_period(input logic ws, input logic d, input logic [DW-1:0] lv, input bit rst_here);
    logic eb;
    bclk  = 1'b0;
    lrclk = ws;
    sdin  = d;
    repeat (2) @(negedge clk);
    if (rst_here) begin
      reset = 1'b1;
      @(negedge clk);
      chk("rst_sdout", sdout, 0);
      chk("rst_in_sample", in_sample, 0);
      chk("rst_sample_ready", sample_ready, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    eb = (m_slot_armed && m_cnt < DW) ? m_slot_word[DW-1-m_cnt] : 1'b0;
    got_w = {got_w[SW-2:0], sdout};
    exp_w = {exp_w[SW-2:0], eb};
    if (ws != m_prev_ws) begin
      if (m_prev_ws && !ws) m_armed = 1'b1;
      m_cnt        = 0;
      m_slot_armed = m_armed;
      m_slot_word  = m_hold;
      if (!ws && m_armed) exp_q.push_back(lv);
    end else if (m_cnt < SW) begin
      m_cnt++;
    end
    m_prev_ws = ws;
    if (!ws && m_armed && m_cnt == DW && !engine_ready) m_ovr = 1'b1;
    bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input logic [DW-1:0] lv, input logic [DW-1:0] rv, input int rst_at,
                       input int eng_drop, input int eng_rise, input logic [DW-1:0] eng_val);
    logic          ws, d;
    logic [DW-1:0] v;
    int            j;
    for (int p = 0; p < 2 * SW; p++) begin
      ws = (p >= SW);
      j  = p % SW;
      v  = ws ? rv : lv;
      d  = (j >= 1 && j <= DW) ? v[DW-j] : 1'b0;
      if (p == eng_drop) engine_ready = 1'b0;
      if (p == eng_rise) begin
        out_sample   = eng_val;
        engine_ready = 1'b1;
        m_hold       = eng_val;
      end
      bit_period(ws, d, lv, p == rst_at);
      if (j == SW - 1) chk(ws ? "sdout_right" : "sdout_left", got_w, exp_w);
    end
    chk("pending_strobes", exp_q.size(), 0);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic engine_pulse(input logic [DW-1:0] val);
    engine_ready = 1'b0;
    repeat (3) @(negedge clk);
    out_sample   = val;
    engine_ready = 1'b1;
    m_hold       = val;
    repeat (3) @(negedge clk);
  endtask

  // scoreboard consumer: every strobe must match the oldest expected sample
  initial begin
    forever begin
      @(negedge clk);
      if (sample_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("spurious_strobe", 1, 0);
        else chk("in_sample", in_sample, exp_q.pop_front());
      end
    end
  end

  initial begin
    got_w = '0;
    exp_w = '0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("reset_sdout", sdout, 0);
    chk("reset_sample_ready", sample_ready, 0);
    // reset released mid-left-slot: partial 0x7FFF never delivered
    frame(16'h7FFF, 16'h1234, 8, -1, -1, '0);
    frame(16'h0F0F, 16'h1234, -1, -1, -1, '0);
    frame(16'h8001, 16'h1234, -1, -1, -1, '0);
    frame(16'h8001, 16'h1234, -1, -1, -1, '0);
    // engine output 0xA5C3, repeated with no further edge
    engine_pulse(16'hA5C3);
    frame(16'h8001, 16'h1234, -1, -1, -1, '0);
    frame(16'hC001, 16'h1234, -1, -1, -1, '0);
    // new engine sample mid-left-slot: takes effect on the right slot
    frame(16'h8001, 16'h1234, -1, 3, 5, 16'h1111);
    // engine not ready at left completion: overrun sets and sticks
    frame(16'h0F0F, 16'h1234, -1, 10, 40, 16'h2222);
    chk("overrun_set", overrun, 1);
    frame(16'h1234, 16'h8001, -1, -1, -1, '0);
    chk("overrun_sticky", overrun, 1);
    // reset mid right-slot transmission, then resume
    frame(16'h7FFF, 16'h1234, 40, -1, -1, '0);
    chk("overrun_cleared", overrun, 0);
    engine_pulse(16'h5A3C);
    frame(16'h8001, 16'hFFFF, -1, -1, -1, '0);
    frame(16'h4321, 16'h0001, -1, -1, -1, '0);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_sample_port.md
# i2s_sample_port

Serial audio front/back end for the sequential DSP engine. Deserialises the codec's I2S input into parallel samples, presents them to the engine with a one-cycle `sample_ready` strobe, captures the engine's `out_sample` when the engine raises `ready`, and serialises it back to the codec. The codec is the I2S master (drives `bclk`/`lrclk`). This block is the engine's only sample source and sink.

## Interface
- `data_width`, 16: sample width, two's complement, MSB-first on the wire.
- `slot_width`, 32: bclk periods per channel slot; must be ≥ `data_width + 1`.
- `sync_stages`, 2: synchroniser flops on `bclk`, `lrclk`, `sdin`; ≥ 2.

- `clk`  in  1  system clock; every register here is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `bclk`  in  1  codec bit clock; asynchronous to `clk`.
- `lrclk`  in  1  codec word select; 0 = left slot, 1 = right slot.
- `sdin`  in  1  codec ADC serial data.
- `sdout`  out  1  serial data to the codec DAC.
- `in_sample`  out  `data_width`  last received left-channel sample; connects to engine `in_sample`.
- `sample_ready`  out  1  one-cycle strobe, `in_sample` valid; connects to engine `sample_ready`.
- `out_sample`  in  `data_width`  engine output sample.
- `engine_ready`  in  1  engine `ready`; a 0→1 transition marks `out_sample` valid.
- `overrun`  out  1  sticky: a sample was delivered while `engine_ready` was low.

## Operation
- Synchronisation: `bclk`, `lrclk`, `sdin` each pass through `sync_stages` flops (outputs `*_s`). A one-flop history of `bclk_s` gives a rise-detect cycle (`bclk_s`=1, previous=0) and a fall-detect cycle (`bclk_s`=0, previous=1).
- Slot tracking, on each rise-detect: compare `lrclk_s` against the `lrclk` sampled at the previous rise. If they differ, `bit_idx` ← 0 and the slot becomes the new `lrclk_s` value. Otherwise `bit_idx` increments, saturating at `slot_width`.
- Arming: after reset, receive and transmit are disarmed. They arm at the first rise-detect that sees a 1→0 `lrclk` change (start of a left slot). No partial frame is ever delivered.
- Receive, armed, left slot: on rise-detect with `bit_idx` (after update) in 1..`data_width`, shift `sdin_s` into `rx_shift` LSB-side. Index 1 is the MSB (standard I2S one-bit delay).
  - When index `data_width` is captured, the same clock edge loads `in_sample` with the completed word and asserts `sample_ready`.
  - If `engine_ready` is 0 in that cycle, `overrun` ← 1. The strobe is still issued.
  - Right-slot data is ignored. Bits beyond `data_width` are ignored.
- Output capture: a 0→1 edge on `engine_ready` (registered history) loads `tx_hold` ← `out_sample`. Later edges overwrite it. With no new edge, `tx_hold` keeps its value, so the previous sample repeats.
- Transmit:
  - On the rise-detect that starts any slot (left or right), load `tx_shift` ← {`tx_hold`, zero pad to `slot_width`}. Both channels carry the same mono sample.
  - On each fall-detect, `sdout` ← `tx_shift` MSB and `tx_shift` shifts left by one, inserting 0.
  - Result: the MSB is driven on the first falling edge after the slot-start rise, then `data_width`−1 further bits, then zeros until the slot ends.
  - While disarmed, `sdout` is 0.
- `tx_hold` changing mid-slot does not affect the slot in progress. It takes effect at the next slot start.
- `overrun` clears only on reset.

## Timing
- Reset (synchronous, 1 cycle sufficient): `sdout`=0, `in_sample`=0, `sample_ready`=0, `overrun`=0. Also cleared: `tx_hold`, shifters, `bit_idx`, edge and `lrclk` histories, synchronisers, armed flag. Reset asserted mid-frame takes effect on the next `clk` edge and the block re-arms at the next left-slot start.
- `clk` frequency ≥ 8× `bclk` frequency. Narrower margins are unsupported.
- Receive latency: pin `bclk` rise carrying the LSB → `sample_ready` high = `sync_stages` + 2 `clk` cycles. `sample_ready` lasts exactly one cycle; exactly one strobe per frame.
- Transmit: `sdout` changes `sync_stages` + 2 `clk` cycles after the pin `bclk` fall, and is stable across the following `bclk` rise.
- `engine_ready` edge → `tx_hold` valid: 1 cycle. Simultaneous engine edge and slot start: the slot loads the old `tx_hold`.
- A sample strobe in the same cycle as an `engine_ready` edge: both actions occur; no priority conflict.

## Test plan
- Reset, then drive frames with `bclk` = `clk`/16, `slot_width` 32. Left = 0x8001, right = 0x1234 → `in_sample`=0x8001, exactly one `sample_ready` pulse per frame, none for the right slot, `overrun`=0 with `engine_ready` held 1.
- Release reset mid-left-slot carrying 0x7FFF, next frame left = 0x0F0F → no strobe for the partial frame; first strobe delivers 0x0F0F; `sdout`=0 until the armed left slot.
- Pulse `engine_ready` 0→1 with `out_sample`=0xA5C3 before a frame → left and right slots each emit 1010010111000011 MSB-first on bclk falls, then 16 zeros. With no further edge, the next frame repeats 0xA5C3.
- `engine_ready` rises with 0x1111 mid-left-slot while transmitting 0xA5C3 → left finishes as 0xA5C3; right slot carries 0x1111.
- Hold `engine_ready`=0 across a left-slot completion → strobe still issued, `overrun`=1. It stays 1 through later good frames and clears only on reset.
- Assert reset for one cycle mid-transmission → next cycle all outputs 0. Resumes correct receive and transmit from the next full left slot.
